// File: rtl/aes_pkg.sv
// Shared AES definitions: forward/inverse S-box tables, the SubBytes engine FSM
// encoding and the standard state size.
package aes_pkg;

  localparam int AES_STATE_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_dual.sv
// One S-box lane: combinational forward or inverse byte substitution chosen by inv.
module aes_sbox_dual
  import aes_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic       inv,
  output logic [7:0] byte_out
);

  assign byte_out = inv ? SBOX_INV[byte_in] : SBOX_FWD[byte_in];

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative SubBytes/InvSubBytes engine: NUM_LANES S-box lanes walk the work register
// lowest byte first, one beat per clock, between two valid/ready handshakes.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int STATE_BYTES = AES_STATE_BYTES,
  parameter int NUM_LANES   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*STATE_BYTES-1:0] in_state,
  input  logic                     in_inv,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*STATE_BYTES-1:0] out_state,
  output logic                     busy
);

  localparam int NBEATS  = STATE_BYTES / NUM_LANES;
  localparam int CNT_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int LANE_W  = 8 * NUM_LANES;
  localparam int STATE_W = 8 * STATE_BYTES;

  if ((STATE_BYTES % NUM_LANES) != 0) begin : g_bad_lanes
    $error("NUM_LANES (%0d) must divide STATE_BYTES (%0d)", NUM_LANES, STATE_BYTES);
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic               inv_q, inv_d;

  logic [LANE_W-1:0]  lane_in;
  logic [LANE_W-1:0]  lane_out;
  logic               last_beat;

  assign lane_in   = work_q[int'(cnt_q) * LANE_W +: LANE_W];
  assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    aes_sbox_dual u_sbox (
      .byte_in  (lane_in[8*j +: 8]),
      .inv      (inv_q),
      .byte_out (lane_out[8*j +: 8])
    );
  end

  // NOTE: every output and next-state variable gets a default before the case, so
  // no path leaves one unassigned and no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    inv_d     = inv_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_state;
          inv_d   = in_inv;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        busy = 1'b1;
        work_d[int'(cnt_q) * LANE_W +: LANE_W] = lane_out;
        if (last_beat) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        // Freeing the result slot lets a waiting state in on the very same edge.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d  = in_state;
            inv_d   = in_inv;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only; the work register is
  // reset too, because out_state must read zero after reset rather than stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      inv_q   <= inv_d;
    end
  end

  assign out_state = work_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: FIPS-197 vectors, inverse, backpressure, lane sweep,
// mid-operation reset and an exhaustive S-box pass against an algebraic GF(2^8) model.
module tb_sub_bytes_engine;

  localparam logic [127:0] T1_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [127:0] T1_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_inv, out_ready;
  logic [127:0] in_state;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_state;

  logic         sw_in_valid, sw_in_inv, sw_out_ready;
  logic [127:0] sw_in_state;
  logic         sw_in_ready  [4];
  logic         sw_out_valid [4];
  logic         sw_busy      [4];
  logic [127:0] sw_out_state [4];

  int           total = 0;
  int           bad   = 0;
  logic [127:0] exp_q [$];
  logic [127:0] last_out;
  logic [7:0]   m_fwd [256];
  logic [7:0]   m_inv [256];

  always #5 clk = ~clk;

  sub_bytes_engine u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  function automatic int lanes_of(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 8;
      default: return 16;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_sw
    sub_bytes_engine #(.STATE_BYTES(16), .NUM_LANES(lanes_of(g))) u_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sw_in_valid),
      .in_ready  (sw_in_ready[g]),
      .in_state  (sw_in_state),
      .in_inv    (sw_in_inv),
      .out_valid (sw_out_valid[g]),
      .out_ready (sw_out_ready),
      .out_state (sw_out_state[g]),
      .busy      (sw_busy[g])
    );
  end

  // Reference S-box from first principles: multiplicative inverse then affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_model();
    logic [7:0] iv, s;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]} ^ {iv[3:0], iv[7:4]} ^ 8'h63;
      m_fwd[x] = s;
      m_inv[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] sub_state(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    for (int k = 0; k < 16; k++)
      r[8*k +: 8] = inv ? m_inv[s[8*k +: 8]] : m_fwd[s[8*k +: 8]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer a state to the main DUT, wait (bounded) for acceptance and log the expected result.
  task automatic send(input logic [127:0] s, input logic inv);
    int n = 0;
    in_valid = 1'b1;
    in_state = s;
    in_inv   = inv;
    #1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_timeout", 128'(n < 50), 128'(1));
    exp_q.push_back(sub_state(s, inv));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge; counts edges until out_valid and scores the result.
  task automatic wait_result(input string tag, input int exp_lat);
    int           lat = 0;
    logic [127:0] exp;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 128'hx;
    last_out = out_state;
    check({tag, "_data"}, out_state, exp);
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic sweep(input logic [127:0] s, input logic inv, input logic [127:0] exp, input string tag);
    bit seen [4];
    for (int g = 0; g < 4; g++) seen[g] = 1'b0;
    sw_in_valid = 1'b1;
    sw_in_state = s;
    sw_in_inv   = inv;
    #1;
    for (int g = 0; g < 4; g++)
      check($sformatf("sw%0d_%s_in_ready", lanes_of(g), tag), 128'(sw_in_ready[g]), 128'(1));
    @(posedge clk); #1;
    sw_in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++) begin
        if (!seen[g] && sw_out_valid[g] === 1'b1) begin
          seen[g] = 1'b1;
          check($sformatf("sw%0d_%s_latency", lanes_of(g), tag), 128'(c), 128'(16 / lanes_of(g)));
          check($sformatf("sw%0d_%s_data", lanes_of(g), tag), sw_out_state[g], exp);
        end
      end
    end
    for (int g = 0; g < 4; g++)
      check($sformatf("sw%0d_%s_seen", lanes_of(g), tag), 128'(seen[g]), 128'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] held;
    logic [127:0] b_state;

    build_model();
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_state     = '0;
    in_inv       = 1'b0;
    out_ready    = 1'b1;
    sw_in_valid  = 1'b0;
    sw_in_state  = '0;
    sw_in_inv    = 1'b0;
    sw_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  128'(in_ready),  128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy",      128'(busy),      128'(0));
    check("rst_out_state", out_state,       128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: FIPS-197 forward vector, 4-cycle latency
    send(T1_IN, 1'b0);
    check("t1_busy", 128'(busy), 128'(1));
    wait_result("t1", 4);
    check("t1_fips", last_out, T1_OUT);

    // T2: inverse recovers the input; fixed-point corner values
    send(T1_OUT, 1'b1);
    wait_result("t2_inv", 4);
    check("t2_fips_inv", last_out, T1_IN);
    send({16{8'h63}}, 1'b1);
    wait_result("t2_63", 4);
    check("t2_inv63_is_00", last_out, 128'(0));
    send({16{8'h00}}, 1'b0);
    wait_result("t2_00", 4);
    check("t2_fwd00_is_63", last_out, {16{8'h63}});
    send({16{8'h53}}, 1'b0);
    wait_result("t2_53", 4);
    check("t2_fwd53_is_ed", last_out, {16{8'hed}});

    // T3: backpressure in DONE, then back-to-back accept on the release edge
    out_ready = 1'b0;
    send(T1_IN, 1'b0);
    wait_result("t3a", 4);
    held = last_out;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_inv   = 1'b1;
      @(posedge clk); #1;
      check($sformatf("t3_hold%0d_out_valid", i), 128'(out_valid), 128'(1));
      check($sformatf("t3_hold%0d_out_state", i), out_state, held);
      check($sformatf("t3_hold%0d_in_ready", i),  128'(in_ready), 128'(0));
      check($sformatf("t3_hold%0d_busy", i),      128'(busy), 128'(0));
    end
    b_state   = {16{8'ha5}};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = b_state;
    in_inv    = 1'b0;
    #1;
    check("t3_release_in_ready", 128'(in_ready), 128'(1));
    send(b_state, 1'b0);
    check("t3_next_busy",      128'(busy),      128'(1));
    check("t3_next_out_valid", 128'(out_valid), 128'(0));
    wait_result("t3b", 4);

    // T4: lane-count sweep, same vectors
    sweep(T1_IN, 1'b0, T1_OUT, "fwd");
    sweep(T1_OUT, 1'b1, T1_IN, "inv");

    // T5: reset in the middle of BUSY discards the state
    send(T1_IN, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_in_ready",  128'(in_ready),  128'(1));
    check("t5_out_valid", 128'(out_valid), 128'(0));
    check("t5_busy",      128'(busy),      128'(0));
    check("t5_out_state", out_state,       128'(0));
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("t5_held%0d_out_valid", i), 128'(out_valid), 128'(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(T1_IN, 1'b0);
    wait_result("t5_after", 4);
    check("t5_after_fips", last_out, T1_OUT);

    // T6: exhaustive S-box, every byte of the state equal to b
    for (int b = 0; b < 256; b++) begin
      for (int m = 0; m < 2; m++) begin
        send({16{8'(b)}}, m[0]);
        wait_result($sformatf("t6_%s_%02h", (m == 0) ? "fwd" : "inv", b), 4);
      end
    end

    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
